simon_axi_fifo_bridge: RTL and testbench

// - Parametrised AXI4 slave bridging the Simon data port to ingress/egress streams; successor of the fixed 128b bridge.
// - Burst-aware: counts AWLEN/ARLEN beats, generates BVALID/BRESP and RLAST itself, and checks WLAST against AWLEN.
// - Internal single-clock FWFT FIFOs of parametrised depth replace the 16x byte-lane BRAM FIFOs; occupancy exported.

---
 rtl/simon_axi_fifo_bridge.sv | 225 ++++++++++++++++++++++
 tb/tb_simon_axi_fifo_bridge.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simon_axi_fifo_bridge.sv
// AXI4 slave bridging the Simon data port to ingress/egress streams through internal FWFT FIFOs.
// Optional macro SIMON_BRIDGE_STRB_CHECK_EN: partial-strobe beats are dropped and flagged SLVERR.
module simon_axi_fifo_bridge #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 8,
  parameter int unsigned FIFO_DEPTH = 512,
  localparam int unsigned CNT_WIDTH = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   s_awaddr,
  input  logic [LEN_WIDTH-1:0]    s_awlen,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  input  logic [DATA_WIDTH-1:0]   s_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_wstrb,
  input  logic                    s_wlast,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  output logic [1:0]              s_bresp,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  input  logic [ADDR_WIDTH-1:0]   s_araddr,
  input  logic [LEN_WIDTH-1:0]    s_arlen,
  input  logic                    s_arvalid,
  output logic                    s_arready,
  output logic [DATA_WIDTH-1:0]   s_rdata,
  output logic [1:0]              s_rresp,
  output logic                    s_rlast,
  output logic                    s_rvalid,
  input  logic                    s_rready,
  output logic [DATA_WIDTH-1:0]   ingress_dout,
  output logic                    ingress_vld,
  input  logic                    ingress_rdy,
  input  logic [DATA_WIDTH-1:0]   egress_din,
  input  logic                    egress_vld,
  output logic                    egress_rdy,
  output logic [CNT_WIDTH-1:0]    ingress_count,
  output logic [CNT_WIDTH-1:0]    egress_count
);

  localparam int unsigned PtrWidth = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
  typedef enum logic {RIdle, RData} r_state_e;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;

  logic [LEN_WIDTH-1:0] awlen_q, awlen_d, wcnt_q, wcnt_d;
  logic [LEN_WIDTH-1:0] arlen_q, arlen_d, rcnt_q, rcnt_d;
  logic                 werr_q, werr_d;
  logic                 run_q, run_d;

  logic [DATA_WIDTH-1:0] in_mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] eg_mem_q [FIFO_DEPTH];
  logic [PtrWidth-1:0]   in_wptr_q, in_wptr_d, in_rptr_q, in_rptr_d;
  logic [PtrWidth-1:0]   eg_wptr_q, eg_wptr_d, eg_rptr_q, eg_rptr_d;
  logic [CNT_WIDTH-1:0]  in_cnt_q, in_cnt_d, eg_cnt_q, eg_cnt_d;

  logic in_full, in_empty, eg_full, eg_empty;
  logic in_push, in_pop, eg_push, eg_pop;
  logic strb_ok, last_beat;

  logic unused_inputs;
  assign unused_inputs = ^{s_awaddr, s_araddr, s_wstrb};

`ifdef SIMON_BRIDGE_STRB_CHECK_EN
  assign strb_ok = &s_wstrb;
`else
  assign strb_ok = 1'b1;
`endif

  assign in_full  = (in_cnt_q == CNT_WIDTH'(FIFO_DEPTH));
  assign in_empty = (in_cnt_q == '0);
  assign eg_full  = (eg_cnt_q == CNT_WIDTH'(FIFO_DEPTH));
  assign eg_empty = (eg_cnt_q == '0);

  assign ingress_count = in_cnt_q;
  assign egress_count  = eg_cnt_q;
  assign ingress_vld   = ~in_empty;
  assign ingress_dout  = ingress_vld ? in_mem_q[in_rptr_q] : '0;
  assign in_pop        = ingress_vld & ingress_rdy;
  // run_q keeps every ready low until the first edge after reset release
  assign egress_rdy    = run_q & ~eg_full;
  assign eg_push       = egress_vld & egress_rdy;
  assign s_rdata       = s_rvalid ? eg_mem_q[eg_rptr_q] : '0;
  assign s_rresp       = 2'b00;
  assign s_bresp       = (s_bvalid && werr_q) ? 2'b10 : 2'b00;
  assign last_beat     = (wcnt_q == awlen_q);
  assign run_d         = 1'b1;

  // Write channel
  always_comb begin
    w_state_d = w_state_q;
    awlen_d   = awlen_q;
    wcnt_d    = wcnt_q;
    werr_d    = werr_q;
    s_awready = 1'b0;
    s_wready  = 1'b0;
    s_bvalid  = 1'b0;
    in_push   = 1'b0;
    unique case (w_state_q)
      WIdle: begin
        s_awready = run_q;
        if (run_q && s_awvalid) begin
          awlen_d   = s_awlen;
          wcnt_d    = '0;
          werr_d    = 1'b0;
          w_state_d = WData;
        end
      end
      WData: begin
        s_wready = ~in_full;
        if (s_wvalid && !in_full) begin
          in_push = strb_ok;
          wcnt_d  = wcnt_q + LEN_WIDTH'(1);
          werr_d  = werr_q | ~strb_ok;
          if (s_wlast || last_beat) begin
            werr_d    = werr_q | ~strb_ok | (s_wlast != last_beat);
            w_state_d = WResp;
          end
        end
      end
      WResp: begin
        s_bvalid = 1'b1;
        if (s_bready) w_state_d = WIdle;
      end
      default: w_state_d = WIdle;
    endcase
  end

  // Read channel
  always_comb begin
    r_state_d = r_state_q;
    arlen_d   = arlen_q;
    rcnt_d    = rcnt_q;
    s_arready = 1'b0;
    s_rvalid  = 1'b0;
    s_rlast   = 1'b0;
    eg_pop    = 1'b0;
    unique case (r_state_q)
      RIdle: begin
        s_arready = run_q;
        if (run_q && s_arvalid) begin
          arlen_d   = s_arlen;
          rcnt_d    = '0;
          r_state_d = RData;
        end
      end
      RData: begin
        s_rvalid = ~eg_empty;
        s_rlast  = (rcnt_q == arlen_q);
        if (s_rready && !eg_empty) begin
          eg_pop = 1'b1;
          rcnt_d = rcnt_q + LEN_WIDTH'(1);
          if (s_rlast) r_state_d = RIdle;
        end
      end
      default: r_state_d = RIdle;
    endcase
  end

  // FIFO pointer and occupancy next state
  always_comb begin
    in_wptr_d = in_wptr_q + PtrWidth'(in_push);
    in_rptr_d = in_rptr_q + PtrWidth'(in_pop);
    eg_wptr_d = eg_wptr_q + PtrWidth'(eg_push);
    eg_rptr_d = eg_rptr_q + PtrWidth'(eg_pop);
    in_cnt_d  = in_cnt_q;
    eg_cnt_d  = eg_cnt_q;
    case ({in_push, in_pop})
      2'b10:   in_cnt_d = in_cnt_q + CNT_WIDTH'(1);
      2'b01:   in_cnt_d = in_cnt_q - CNT_WIDTH'(1);
      default: in_cnt_d = in_cnt_q;
    endcase
    case ({eg_push, eg_pop})
      2'b10:   eg_cnt_d = eg_cnt_q + CNT_WIDTH'(1);
      2'b01:   eg_cnt_d = eg_cnt_q - CNT_WIDTH'(1);
      default: eg_cnt_d = eg_cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state_q <= WIdle;
      r_state_q <= RIdle;
      awlen_q   <= '0;
      wcnt_q    <= '0;
      werr_q    <= 1'b0;
      arlen_q   <= '0;
      rcnt_q    <= '0;
      run_q     <= 1'b0;
      in_wptr_q <= '0;
      in_rptr_q <= '0;
      in_cnt_q  <= '0;
      eg_wptr_q <= '0;
      eg_rptr_q <= '0;
      eg_cnt_q  <= '0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      awlen_q   <= awlen_d;
      wcnt_q    <= wcnt_d;
      werr_q    <= werr_d;
      arlen_q   <= arlen_d;
      rcnt_q    <= rcnt_d;
      run_q     <= run_d;
      in_wptr_q <= in_wptr_d;
      in_rptr_q <= in_rptr_d;
      in_cnt_q  <= in_cnt_d;
      eg_wptr_q <= eg_wptr_d;
      eg_rptr_q <= eg_rptr_d;
      eg_cnt_q  <= eg_cnt_d;
    end
  end

  // Storage is not reset; occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (in_push) in_mem_q[in_wptr_q] <= s_wdata;
    if (eg_push) eg_mem_q[eg_wptr_q] <= egress_din;
  end

endmodule

// File: tb/tb_simon_axi_fifo_bridge.sv
// Self-checking bench for simon_axi_fifo_bridge: queue-based AXI/stream model plus directed bursts.
module tb_simon_axi_fifo_bridge;
  localparam int DW    = 32;
  localparam int AWID  = 32;
  localparam int LW    = 8;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic            clk, rst;
  logic [AWID-1:0] s_awaddr, s_araddr;
  logic [LW-1:0]   s_awlen, s_arlen;
  logic            s_awvalid, s_awready, s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [DW-1:0]   s_wdata, s_rdata, ingress_dout, egress_din;
  logic [DW/8-1:0] s_wstrb;
  logic [1:0]      s_bresp, s_rresp;
  logic            s_arvalid, s_arready, s_rlast, s_rvalid, s_rready;
  logic            ingress_vld, ingress_rdy, egress_vld, egress_rdy;
  logic [CW-1:0]   ingress_count, egress_count;

  simon_axi_fifo_bridge #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AWID), .LEN_WIDTH(LW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid),
    .s_wready(s_wready), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid),
    .s_rready(s_rready), .ingress_dout(ingress_dout), .ingress_vld(ingress_vld),
    .ingress_rdy(ingress_rdy), .egress_din(egress_din), .egress_vld(egress_vld),
    .egress_rdy(egress_rdy), .ingress_count(ingress_count), .egress_count(egress_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: queues for FIFO contents, phase per AXI channel
  logic [DW-1:0] in_q[$];
  logic [DW-1:0] eg_q[$];
  int w_phase = 0, r_phase = 0;
  int m_awlen = 0, m_wcnt = 0, m_arlen = 0, m_rcnt = 0;
  bit m_werr = 0, m_run = 0;

  always @(posedge clk) begin : model
    bit aw_hs, w_hs, b_hs, ar_hs, r_hs, in_pop, eg_push, last, strb_ok;
    if (!rst) begin
      in_q.delete();
      eg_q.delete();
      w_phase = 0;
      r_phase = 0;
      m_werr  = 0;
      m_run   = 0;
    end else begin
      aw_hs   = m_run && w_phase == 0 && s_awvalid;
      w_hs    = w_phase == 1 && in_q.size() < DEPTH && s_wvalid;
      b_hs    = w_phase == 2 && s_bready;
      ar_hs   = m_run && r_phase == 0 && s_arvalid;
      r_hs    = r_phase == 1 && eg_q.size() > 0 && s_rready;
      in_pop  = in_q.size() > 0 && ingress_rdy;
      eg_push = m_run && eg_q.size() < DEPTH && egress_vld;
      strb_ok = 1'b1;
`ifdef SIMON_BRIDGE_STRB_CHECK_EN
      strb_ok = (s_wstrb == '1);
`endif
      if (in_pop) void'(in_q.pop_front());
      if (r_hs) begin
        void'(eg_q.pop_front());
        if (m_rcnt == m_arlen) r_phase = 0;
        m_rcnt++;
      end
      if (eg_push) eg_q.push_back(egress_din);
      if (w_hs) begin
        last = (m_wcnt == m_awlen);
        if (strb_ok) in_q.push_back(s_wdata);
        else m_werr = 1;
        if (s_wlast || last) begin
          if (s_wlast != last) m_werr = 1;
          w_phase = 2;
        end
        m_wcnt++;
      end
      if (b_hs) w_phase = 0;
      if (aw_hs) begin
        m_awlen = int'(s_awlen);
        m_wcnt  = 0;
        m_werr  = 0;
        w_phase = 1;
      end
      if (ar_hs) begin
        m_arlen = int'(s_arlen);
        m_rcnt  = 0;
        r_phase = 1;
      end
      m_run = 1;
    end
  end

  always @(negedge clk) begin : compare
    if (!rst) begin
      chk("rst_awready", s_awready, 0);
      chk("rst_wready", s_wready, 0);
      chk("rst_bvalid", s_bvalid, 0);
      chk("rst_bresp", s_bresp, 0);
      chk("rst_arready", s_arready, 0);
      chk("rst_rvalid", s_rvalid, 0);
      chk("rst_rlast", s_rlast, 0);
      chk("rst_rresp", s_rresp, 0);
      chk("rst_ingress_vld", ingress_vld, 0);
      chk("rst_egress_rdy", egress_rdy, 0);
      chk("rst_ingress_count", ingress_count, 0);
      chk("rst_egress_count", egress_count, 0);
    end else begin
      chk("awready", s_awready, m_run && w_phase == 0);
      chk("wready", s_wready, w_phase == 1 && in_q.size() < DEPTH);
      chk("bvalid", s_bvalid, w_phase == 2);
      if (w_phase == 2) chk("bresp", s_bresp, m_werr ? 2'b10 : 2'b00);
      chk("arready", s_arready, m_run && r_phase == 0);
      chk("rvalid", s_rvalid, r_phase == 1 && eg_q.size() > 0);
      if (r_phase == 1 && eg_q.size() > 0) begin
        chk("rdata", s_rdata, eg_q[0]);
        chk("rlast", s_rlast, m_rcnt == m_arlen);
      end
      chk("rresp", s_rresp, 0);
      chk("ingress_vld", ingress_vld, in_q.size() > 0);
      if (in_q.size() > 0) chk("ingress_dout", ingress_dout, in_q[0]);
      chk("egress_rdy", egress_rdy, m_run && eg_q.size() < DEPTH);
      chk("ingress_count", ingress_count, in_q.size());
      chk("egress_count", egress_count, eg_q.size());
    end
  end

  // Observed traffic for the literal expectations
  logic [DW-1:0] seen_in[$];
  logic [DW:0]   seen_r[$];
  int bvalid_cycles = 0;
  int b_hs_cnt = 0;

  always @(negedge clk) begin : monitor
    if (rst) begin
      if (ingress_vld && ingress_rdy) seen_in.push_back(ingress_dout);
      if (s_rvalid && s_rready) seen_r.push_back({s_rlast, s_rdata});
      if (s_bvalid) bvalid_cycles++;
      if (s_bvalid && s_bready) b_hs_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_aw(input int len);
    bit ok = 0;
    s_awvalid = 1'b1;
    s_awlen   = LW'(len);
    s_awaddr  = $urandom;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = s_awready;
      tick();
    end
    chk("aw_accepted", ok, 1);
    s_awvalid = 1'b0;
  endtask

  task automatic do_w(input logic [DW-1:0] data, input bit last, input logic [DW/8-1:0] strb);
    bit ok = 0;
    s_wvalid = 1'b1;
    s_wdata  = data;
    s_wlast  = last;
    s_wstrb  = strb;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = s_wready;
      tick();
    end
    chk("w_accepted", ok, 1);
    s_wvalid = 1'b0;
    s_wlast  = 1'b0;
  endtask

  task automatic do_b(output logic [1:0] resp);
    bit ok = 0;
    resp     = 2'bxx;
    s_bready = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = s_bvalid;
      if (ok) resp = s_bresp;
      tick();
    end
    chk("b_seen", ok, 1);
    s_bready = 1'b0;
  endtask

  task automatic do_ar(input int len);
    bit ok = 0;
    s_arvalid = 1'b1;
    s_arlen   = LW'(len);
    s_araddr  = $urandom;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = s_arready;
      tick();
    end
    chk("ar_accepted", ok, 1);
    s_arvalid = 1'b0;
  endtask

  task automatic do_eg(input logic [DW-1:0] data);
    bit ok = 0;
    egress_vld = 1'b1;
    egress_din = data;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = egress_rdy;
      tick();
    end
    chk("eg_accepted", ok, 1);
    egress_vld = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin : stimulus
    logic [1:0] resp;
    int b_before;
    rst = 1'b0;
    {s_awaddr, s_awlen, s_awvalid, s_wdata, s_wlast, s_wvalid, s_bready} = '0;
    {s_araddr, s_arlen, s_arvalid, s_rready, egress_din, egress_vld} = '0;
    s_wstrb     = '1;
    ingress_rdy = 1'b0;
    repeat (3) tick();
    chk("reset_awready_lit", s_awready, 0);
    chk("reset_egress_rdy_lit", egress_rdy, 0);
    rst = 1'b1;
    tick();

    // 4-beat burst, correct WLAST
    ingress_rdy = 1'b1;
    seen_in.delete();
    b_before = b_hs_cnt;
    do_aw(3);
    for (int i = 1; i <= 4; i++) do_w(DW'(i), i == 4, '1);
    do_b(resp);
    chk("t1_bresp", resp, 2'b00);
    repeat (4) tick();
    chk("t1_b_once", b_hs_cnt - b_before, 1);
    chk("t1_nwords", seen_in.size(), 4);
    for (int i = 0; i < 4 && i < seen_in.size(); i++) chk("t1_word", seen_in[i], i + 1);

    // Early WLAST on beat 2 of 4
    seen_in.delete();
    do_aw(3);
    do_w(32'h5, 1'b0, '1);
    do_w(32'h6, 1'b1, '1);
    do_b(resp);
    chk("t2_bresp", resp, 2'b10);
    repeat (3) tick();
    chk("t2_nwords", seen_in.size(), 2);
    do_aw(0);
    do_w(32'h7, 1'b1, '1);
    do_b(resp);
    chk("t2_next_bresp", resp, 2'b00);

    // Missing WLAST on final beat
    do_aw(1);
    do_w(32'h8, 1'b0, '1);
    do_w(32'h9, 1'b0, '1);
    do_b(resp);
    chk("t2b_bresp", resp, 2'b10);
    repeat (3) tick();

    // Fill ingress to DEPTH with the sink stalled
    ingress_rdy = 1'b0;
    do_aw(9);
    for (int i = 0; i < DEPTH; i++) do_w(DW'(16 + i), 1'b0, '1);
    s_wvalid = 1'b1;
    s_wdata  = 32'd24;
    @(negedge clk);
    chk("full_wready", s_wready, 0);
    chk("full_count", ingress_count, DEPTH);
    tick();
    ingress_rdy = 1'b1;
    tick();
    ingress_rdy = 1'b0;
    @(negedge clk);
    chk("after_pop_wready", s_wready, 1);
    chk("after_pop_count", ingress_count, DEPTH - 1);
    tick();
    s_wvalid    = 1'b0;
    ingress_rdy = 1'b1;
    do_w(32'd25, 1'b1, '1);
    do_b(resp);
    chk("t3_bresp", resp, 2'b00);
    repeat (DEPTH + 4) tick();
    chk("t3_drained", ingress_count, 0);

    // Read burst against an empty egress FIFO
    seen_r.delete();
    do_ar(1);
    repeat (3) tick();
    @(negedge clk);
    chk("t4_empty_rvalid", s_rvalid, 0);
    tick();
    do_eg(32'hA);
    do_eg(32'hB);
    @(negedge clk);
    chk("t4_head_rdata", s_rdata, 32'hA);
    chk("t4_head_rlast", s_rlast, 0);
    tick();
    s_rready = 1'b1;
    for (int i = 0; i < 20 && seen_r.size() < 2; i++) tick();
    s_rready = 1'b0;
    chk("t4_nbeats", seen_r.size(), 2);
    if (seen_r.size() == 2) begin
      chk("t4_beat0", seen_r[0], {1'b0, 32'hA});
      chk("t4_beat1", seen_r[1], {1'b1, 32'hB});
    end
    tick();

    // Reset in the middle of a write burst
    ingress_rdy = 1'b0;
    do_aw(3);
    do_w(32'h31, 1'b0, '1);
    do_w(32'h32, 1'b0, '1);
    chk("t5_pre_count", ingress_count, 2);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_count_lit", ingress_count, 0);
    chk("t5_vld_lit", ingress_vld, 0);
    tick();
    tick();
    rst           = 1'b1;
    ingress_rdy   = 1'b1;
    bvalid_cycles = 0;
    repeat (10) tick();
    chk("t5_no_bvalid", bvalid_cycles, 0);
    do_aw(0);
    do_w(32'h40, 1'b1, '1);
    do_b(resp);
    chk("t5_recover_bresp", resp, 2'b00);
    repeat (3) tick();

    // Partial strobe on beat 2
    seen_in.delete();
    do_aw(1);
    do_w(32'h51, 1'b0, '1);
    do_w(32'h52, 1'b1, 4'b0011);
    do_b(resp);
    repeat (3) tick();
`ifdef SIMON_BRIDGE_STRB_CHECK_EN
    chk("t6_bresp", resp, 2'b10);
    chk("t6_nwords", seen_in.size(), 1);
`else
    chk("t6_bresp", resp, 2'b00);
    chk("t6_nwords", seen_in.size(), 2);
`endif

    repeat (5) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
